uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 16 +
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_rx_fifo.sv | 88 ++++++++
 tb/tb_uart_rx_fifo.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: line timing, frame format and receive FIFO sizing.
// Imported by every file of the receive path.
package uart_rx_fifo_pkg;

    localparam int CLK_HZ       = 50_000_000;
    localparam int BAUD         = 115_200;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int DATA_BITS    = 8;
    localparam int STOP_BITS    = 1;

    localparam int FIFO_DEPTH   = 16;
    localparam int FIFO_ADDR_W  = 4;

    typedef logic [DATA_BITS-1:0] byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream between the UART receiver, the RX FIFO and its consumer.
// master = receiver/consumer side, slave = FIFO side.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) ();

    byte_t             wr_data;
    logic              wr_valid;
    logic              rd_en;
    logic              clear_ovf;
    byte_t             rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport master (
        output wr_data, wr_valid, rd_en, clear_ovf,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    modport slave (
        input  wr_data, wr_valid, rd_en, clear_ovf,
        output rd_data, rd_valid, empty, full, count, overflow
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 storage array: synchronous write, combinational read.
// Deliberately unreset; valid data is tracked by the pointers and count.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  byte_t             wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output byte_t             rdata_o
);

    byte_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and its consumer.
// Owns pointers, occupancy count, sticky overflow and the registered read port.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    byte_t             rd_data_q, rd_data_d;
    logic              rd_valid_q;

    logic  empty, full;
    logic  rd_acc, wr_acc;
    byte_t mem_rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // A read frees a slot in the same cycle, so a full FIFO may still accept.
    assign rd_acc = bus.rd_en & ~empty;
    assign wr_acc = bus.wr_valid & (~full | rd_acc);

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wr_ptr_d  = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        rd_data_d = rd_acc ? mem_rdata : rd_data_q;
        count_d   = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Set beats clear when both happen together.
        ovf_d = ovf_q;
        if (bus.clear_ovf) ovf_d = 1'b0;
        if (bus.wr_valid && !wr_acc) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_acc;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, full/empty corners,
// overflow set/clear priority, pointer wrap and asynchronous reset.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();

    uart_rx_fifo #(
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wr_data  = d;
        bus.wr_valid = 1'b1;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] d, input string tag);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.rd_data), 32'(d));
    endtask

    initial begin
        rst           = 1'b1;
        bus.wr_data   = 8'h00;
        bus.wr_valid  = 1'b0;
        bus.rd_en     = 1'b0;
        bus.clear_ovf = 1'b0;
        repeat (2) step();
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_rvalid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rdata", 32'(bus.rd_data), 32'h00);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;

        // Two bytes in, two bytes out
        wr(8'hA5);
        chk("two_cnt1", 32'(bus.count), 32'd1);
        wr(8'h3C);
        chk("two_cnt2", 32'(bus.count), 32'd2);
        rd(8'hA5, "two_rd0");
        chk("two_cnt_a", 32'(bus.count), 32'd1);
        rd(8'h3C, "two_rd1");
        chk("two_cnt_b", 32'(bus.count), 32'd0);
        chk("two_empty", 32'(bus.empty), 32'd1);
        step();
        chk("two_pulse", 32'(bus.rd_valid), 32'd0);
        chk("two_hold", 32'(bus.rd_data), 32'h3C);

        // Read while empty is ignored
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk("erd_valid", 32'(bus.rd_valid), 32'd0);
        chk("erd_data", 32'(bus.rd_data), 32'h3C);
        chk("erd_count", 32'(bus.count), 32'd0);

        // 17 writes into 16 entries
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_cnt16", 32'(bus.count), 32'd16);
        chk("ovf_pre", 32'(bus.overflow), 32'd0);
        wr(8'h10);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_cnt", 32'(bus.count), 32'd16);
        bus.clear_ovf = 1'b1;
        step();
        bus.clear_ovf = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // Write and read together while full
        bus.wr_data  = 8'h55;
        bus.wr_valid = 1'b1;
        bus.rd_en    = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        chk("fwr_valid", 32'(bus.rd_valid), 32'd1);
        chk("fwr_data", 32'(bus.rd_data), 32'h00);
        chk("fwr_cnt", 32'(bus.count), 32'd16);
        chk("fwr_ovf", 32'(bus.overflow), 32'd0);

        // Clear in the same cycle as a dropped write: set wins
        bus.wr_data   = 8'hEE;
        bus.wr_valid  = 1'b1;
        bus.clear_ovf = 1'b1;
        step();
        bus.wr_valid  = 1'b0;
        bus.clear_ovf = 1'b0;
        chk("prio_ovf", 32'(bus.overflow), 32'd1);
        chk("prio_cnt", 32'(bus.count), 32'd16);
        step();
        chk("prio_keep", 32'(bus.overflow), 32'd1);
        bus.clear_ovf = 1'b1;
        step();
        bus.clear_ovf = 1'b0;
        chk("prio_clr", 32'(bus.overflow), 32'd0);

        for (int i = 1; i < 16; i++) rd(8'(i), "drain");
        rd(8'h55, "drain_last");
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Fill, drain 10, refill 10 across the pointer wrap
        for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
        chk("wrap_full", 32'(bus.count), 32'd16);
        for (int i = 0; i < 10; i++) rd(8'(8'h80 + i), "wrap_a");
        chk("wrap_cnt6", 32'(bus.count), 32'd6);
        for (int i = 0; i < 10; i++) wr(8'(8'hC0 + i));
        chk("wrap_cnt16", 32'(bus.count), 32'd16);
        chk("wrap_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 10; i < 16; i++) rd(8'(8'h80 + i), "wrap_b");
        for (int i = 0; i < 10; i++) rd(8'(8'hC0 + i), "wrap_c");
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Write and read together while empty
        bus.wr_data  = 8'h77;
        bus.wr_valid = 1'b1;
        bus.rd_en    = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        chk("ewr_cnt", 32'(bus.count), 32'd1);
        chk("ewr_valid", 32'(bus.rd_valid), 32'd0);

        // Reset with an in-flight read at count 5
        for (int i = 0; i < 5; i++) wr(8'(8'h11 + i));
        chk("rr_cnt6", 32'(bus.count), 32'd6);
        bus.rd_en = 1'b1;
        step();
        chk("rr_valid1", 32'(bus.rd_valid), 32'd1);
        chk("rr_data1", 32'(bus.rd_data), 32'h77);
        chk("rr_cnt5", 32'(bus.count), 32'd5);
        rst = 1'b1;
        #1;
        chk("rr_valid0", 32'(bus.rd_valid), 32'd0);
        chk("rr_cnt0", 32'(bus.count), 32'd0);
        chk("rr_empty", 32'(bus.empty), 32'd1);
        chk("rr_data0", 32'(bus.rd_data), 32'h00);
        step();
        bus.rd_en = 1'b0;
        rst = 1'b0;
        chk("rr_after_v", 32'(bus.rd_valid), 32'd0);

        // First edge after release takes a write
        wr(8'h9E);
        chk("post_cnt", 32'(bus.count), 32'd1);
        chk("post_valid", 32'(bus.rd_valid), 32'd0);
        chk("post_data", 32'(bus.rd_data), 32'h00);
        rd(8'h9E, "post_rd");
        chk("post_empty", 32'(bus.empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
